apb_master: RTL

- APB initiator that drives the I2S transceiver's APB register slave: control register (0x00), Tx data (0x20), Rx data (0x40).
- Accepts single read/write commands from a local controller (test sequencer or host-side CPU shim) over a valid/ready interface.
- Executes each command as one APB SETUP/ACCESS transfer and returns read data and an error flag over a buffered response channel.
- Includes a wait-state watchdog so a hung slave cannot stall the host.

---
 rtl/apb_master.sv | 121 ++++++++++++
 1 files changed

// File: rtl/apb_master.sv
// APB initiator: turns single valid/ready read/write commands into APB SETUP/ACCESS
// transfers and returns data/error through a one-deep response buffer, with a wait-state watchdog.
module apb_master #(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned TIMEOUT = 16
) (
   input  logic              pclk,
   input  logic              preset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              psel,
   output logic              penable,
   output logic              pwrite,
   output logic [ADDR_W-1:0] paddr,
   output logic [DATA_W-1:0] pwdata,
   input  logic [DATA_W-1:0] prdata,
   input  logic              pready,
   input  logic              pslverr
);

   localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

   state_e              state_q, state_d;
   logic [CntW-1:0]     wdog_q, wdog_d;
   logic                pwrite_q, pwrite_d;
   logic [ADDR_W-1:0]   paddr_q, paddr_d;
   logic [DATA_W-1:0]   pwdata_q, pwdata_d;
   logic                rsp_valid_q, rsp_valid_d;
   logic                rsp_err_q, rsp_err_d;
   logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
   logic                timeout;

   always_comb begin
      state_d     = state_q;
      wdog_d      = wdog_q;
      pwrite_d    = pwrite_q;
      paddr_d     = paddr_q;
      pwdata_d    = pwdata_q;
      rsp_valid_d = rsp_valid_q;
      rsp_err_d   = rsp_err_q;
      rsp_rdata_d = rsp_rdata_q;
      cmd_ready   = 1'b0;
      timeout     = 1'b0;

      if (rsp_valid_q && rsp_ready) begin
         rsp_valid_d = 1'b0;
      end

      unique case (state_q)
         StIdle: begin
            // Gated by reset so the handshake reads 0 while reset is held.
            cmd_ready = preset && (!rsp_valid_q || rsp_ready);
            if (cmd_valid && cmd_ready) begin
               pwrite_d = cmd_write;
               paddr_d  = cmd_addr;
               pwdata_d = cmd_wdata;
               state_d  = StSetup;
            end
         end
         StSetup: begin
            state_d = StAccess;
         end
         StAccess: begin
            timeout = (TIMEOUT != 0) && !pready && (32'(wdog_q) == TIMEOUT - 1);
            wdog_d  = wdog_q + CntW'(1);
            if (pready || timeout) begin
               state_d     = StIdle;
               wdog_d      = '0;
               rsp_valid_d = 1'b1;
               rsp_err_d   = timeout ? 1'b1 : pslverr;
               rsp_rdata_d = (!pwrite_q && !pslverr && !timeout) ? prdata : '0;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge pclk or negedge preset) begin
      if (!preset) begin
         state_q     <= StIdle;
         wdog_q      <= '0;
         pwrite_q    <= 1'b0;
         paddr_q     <= '0;
         pwdata_q    <= '0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         wdog_q      <= wdog_d;
         pwrite_q    <= pwrite_d;
         paddr_q     <= paddr_d;
         pwdata_q    <= pwdata_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rsp_rdata_q <= rsp_rdata_d;
      end
   end

   assign psel      = (state_q != StIdle);
   assign penable   = (state_q == StAccess);
   assign pwrite    = pwrite_q;
   assign paddr     = paddr_q;
   assign pwdata    = pwdata_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_err   = rsp_err_q;
   assign rsp_rdata = rsp_rdata_q;

endmodule
